// File: rtl/rf_wb_queue.sv
//------------------------------------------------------------------------------
// rf_wb_queue
//
// Write-back buffer in front of the register file's single write port.
// Execution-side write requests are accepted through a valid/ready handshake.
// They are queued in a small circular FIFO. At most one entry is drained per
// cycle onto WrEn/Rw/busW. Two bypass ports let operand readers see values
// that are queued but not yet written.
//
// Parameters:
//   DEPTH    number of queue entries (power of 2, at least 2)
//   AW       pointer width, log2(DEPTH)
//
// Ports:
//   Clk, Rst_n            clock (rising edge), async active-low reset
//   ReqValid/ReqReady     request handshake
//   ReqRw/ReqData         request destination register and data
//   Stall                 holds the drain (no write this cycle)
//   WrEn/Rw/busW          register-file write port
//   QRa/QRb               bypass lookup addresses
//   HitA/HitB, FwdA/FwdB  bypass hit flags and youngest matching data
//   Count/Empty           occupancy (0..DEPTH) and empty flag
//------------------------------------------------------------------------------
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic [4:0]    ReqRw,
    input  logic [31:0]   ReqData,
    input  logic          Stall,
    output logic          WrEn,
    output logic [4:0]    Rw,
    output logic [31:0]   busW,
    input  logic [4:0]    QRa,
    input  logic [4:0]    QRb,
    output logic          HitA,
    output logic          HitB,
    output logic [31:0]   FwdA,
    output logic [31:0]   FwdB,
    output logic [AW:0]   Count,
    output logic          Empty
);

    localparam logic [AW:0]   FullCount = DEPTH[AW:0];
    localparam logic [AW:0]   CountOne  = 1;
    localparam logic [AW-1:0] PtrOne    = 1;

    logic [4:0]       rwMem   [DEPTH];
    logic [31:0]      dataMem [DEPTH];
    logic [DEPTH-1:0] validMem;
    logic [AW-1:0]    headPtr;
    logic [AW-1:0]    tailPtr;
    logic [AW:0]      countReg;
    logic             doPush;
    logic             doPop;
    logic [AW-1:0]    slot;

    // Occupancy flags come from the registered count only. A full queue
    // refuses a push even in a cycle where it is also draining.
    assign Count    = countReg;
    assign Empty    = (countReg == '0);
    assign ReqReady = (countReg < FullCount);

    // A request to register 0 completes the handshake but is never stored.
    // Register 0 is hard-wired, so a write to it would be a no-op anyway.
    assign doPush = ReqValid && ReqReady && (ReqRw != 5'd0);
    assign doPop  = WrEn;

    // The head entry is presented whenever the queue holds something.
    // Stall only suppresses the enable, so Rw/busW stay visible while stalled.
    assign WrEn = !Empty && !Stall;
    assign Rw   = Empty ? 5'd0  : rwMem[headPtr];
    assign busW = Empty ? 32'd0 : dataMem[headPtr];

    // Pointer, occupancy and valid-flag state. Pointers wrap naturally
    // because DEPTH is a power of two. Full and empty are told apart by
    // countReg, never by comparing the pointers. A push and a pop never
    // touch the same slot: pushing needs a non-full queue, popping needs a
    // non-empty one.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            countReg <= '0;
            validMem <= '0;
        end else begin
            if (doPush) begin
                tailPtr           <= tailPtr + PtrOne;
                validMem[tailPtr] <= 1'b1;
            end
            if (doPop) begin
                headPtr           <= headPtr + PtrOne;
                validMem[headPtr] <= 1'b0;
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + CountOne;
                2'b01:   countReg <= countReg - CountOne;
                default: countReg <= countReg;
            endcase
        end
    end

    // Payload storage needs no reset. The valid flags and countReg decide
    // which slots are meaningful.
    always_ff @(posedge Clk) begin
        if (doPush) begin
            rwMem[tailPtr]   <= ReqRw;
            dataMem[tailPtr] <= ReqData;
        end
    end

    // Bypass search over the stored entries only, so a request being pushed
    // this cycle is not visible yet. The head being popped this cycle still
    // is. Slots are walked oldest to youngest and every match overwrites the
    // previous one, so the youngest match is what remains.
    always_comb begin
        HitA = 1'b0;
        FwdA = 32'd0;
        HitB = 1'b0;
        FwdB = 32'd0;
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = headPtr + i[AW-1:0];
            if ((i[AW:0] < countReg) && validMem[slot]) begin
                if ((QRa != 5'd0) && (rwMem[slot] == QRa)) begin
                    HitA = 1'b1;
                    FwdA = dataMem[slot];
                end
                if ((QRb != 5'd0) && (rwMem[slot] == QRb)) begin
                    HitB = 1'b1;
                    FwdB = dataMem[slot];
                end
            end
        end
    end

endmodule
